// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: requester, nibble-stream and eth_udp_send signals of the TX arbiter
interface udp_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [4*NUM_REQ-1:0] nib_d;
   logic [NUM_REQ-1:0]   nib_valid;
   logic [NUM_REQ-1:0]   nib_ready;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   done;
   logic                 eth_rdy;
   logic                 mac_busy;
   logic                 wr_full;
   logic                 wr_en;
   logic [3:0]           wr_d;
   logic                 busy;
   logic                 timeout;
   modport master (
      output req, nib_d, nib_valid, eth_rdy, mac_busy, wr_full,
      input  nib_ready, grant, done, wr_en, wr_d, busy, timeout
   );
   modport slave (
      input  req, nib_d, nib_valid, eth_rdy, mac_busy, wr_full,
      output nib_ready, grant, done, wr_en, wr_d, busy, timeout
   );
endinterface

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin owner of the eth_udp_send write port, one frame per grant.
// Define UDP_ARB_TIMEOUT_EN to add a watchdog on the MAC busy handshake.
module udp_tx_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int DATA_BYTES     = 256,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic             clk,
   input logic             rstn,
   udp_tx_arbiter_if.slave bus
);
   localparam int IW   = $clog2(NUM_REQ);
   localparam int CB   = $clog2(2 * DATA_BYTES + 1);
   localparam int CW   = (CB > 10) ? CB : 10;
   localparam int LAST = 2 * DATA_BYTES - 1;
   typedef enum logic [1:0] {IDLE, STREAM, WAIT_BUSY, WAIT_IDLE} state_t;
   state_t             state, state_n;
   logic [NUM_REQ-1:0] grant_q, done_q, ready;
   logic [IW-1:0]      ptr, gidx, sel_idx, j;
   logic [CW-1:0]      cnt;
   logic [3:0]         nib, wr_d_q;
   logic               sel_ok, start, xfer, last, tmo, fin;
   logic               wr_en_q, busy_q, timeout_q;
   assign ready         = (state == STREAM && !bus.wr_full) ? grant_q : '0;
   assign xfer          = |(bus.nib_valid & ready);
   assign last          = xfer && cnt == CW'(LAST);
   assign start         = state == IDLE && bus.eth_rdy && sel_ok;
   assign fin           = (state == WAIT_IDLE && !bus.mac_busy) || tmo;
   assign bus.nib_ready = ready;
   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_d      = wr_d_q;
   assign bus.busy      = busy_q;
   assign bus.timeout   = timeout_q;
   // first requesting index at or after the pointer; lower k overrides so the nearest wins
   always_comb begin
      sel_ok  = 1'b0;
      sel_idx = '0;
      j       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % NUM_REQ);
         if (bus.req[j]) begin
            sel_ok  = 1'b1;
            sel_idx = j;
         end
      end
   end
   // nibble of the current owner
   always_comb begin
      nib = 4'h0;
      for (int k = 0; k < NUM_REQ; k++)
         if (grant_q[k]) nib = bus.nib_d[4*k +: 4];
   end
   // frame sequencing; the watchdog can cut either MAC wait short
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = start ? STREAM : IDLE;
         STREAM:    state_n = last ? WAIT_BUSY : STREAM;
         WAIT_BUSY: state_n = bus.mac_busy ? WAIT_IDLE : WAIT_BUSY;
         default:   state_n = bus.mac_busy ? WAIT_IDLE : IDLE;
      endcase
      if (tmo) state_n = IDLE;
   end
   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end
   // grant, pointer, nibble count and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         grant_q   <= '0;
         done_q    <= '0;
         ptr       <= '0;
         gidx      <= '0;
         cnt       <= '0;
         wr_en_q   <= 1'b0;
         wr_d_q    <= 4'h0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         wr_en_q   <= xfer;
         done_q    <= fin ? grant_q : '0;
         timeout_q <= tmo;
         busy_q    <= state_n != IDLE;
         if (xfer) wr_d_q <= nib;
         if (xfer) cnt <= last ? '0 : cnt + 1'b1;
         if (start) begin
            grant_q <= NUM_REQ'(1) << sel_idx;
            gidx    <= sel_idx;
         end
         if (fin) begin
            grant_q <= '0;
            ptr     <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
         end
      end
   end
`ifdef UDP_ARB_TIMEOUT_EN
   logic [31:0] tcnt;
   assign tmo = (state == WAIT_BUSY || state == WAIT_IDLE) && tcnt == 32'(TIMEOUT_CYCLES - 1);
   // watchdog count restarts on every state change
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tcnt <= '0;
      else       tcnt <= (state_n != state) ? '0 : tcnt + 1'b1;
   end
`else
   logic unused_timeout;
   assign tmo            = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
endmodule
